// File: rtl/axi_stream_strip_header.sv
// axi_stream_strip_header: removes a 0..DATA_BYTE_WD-1 byte header from each AXI-Stream packet
// Ports:
//   clk, rst_n                                   clock, asynchronous active-low reset
//   valid_in/ready_in, data_in, keep_in, last_in input packet stream
//   valid_out/ready_out, data_out, keep_out, last_out  re-aligned payload, keep left-aligned
//   valid_strip/ready_strip, byte_strip_cnt      per-packet header length c
//   valid_header/ready_header, data_header, keep_header  stripped header, right-aligned
// Optional: define AXIS_STRIP_HEADER_OUT_EN to drive the header port; otherwise it is tied 0.
module axi_stream_strip_header #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_in,
   output logic                    ready_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   output logic                    valid_out,
   input  logic                    ready_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   input  logic                    valid_strip,
   output logic                    ready_strip,
   input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
   output logic                    valid_header,
   input  logic                    ready_header,
   output logic [DATA_WD-1:0]      data_header,
   output logic [DATA_BYTE_WD-1:0] keep_header
);
   localparam int CW = BYTE_CNT_WD + 1;
   typedef enum logic [1:0] {IDLE, FIRST, BODY, FLUSH} state_t;
   state_t state, state_nxt;
   logic [BYTE_CNT_WD-1:0] c;
   logic [CW-1:0] cc, n, rem, take, r_cnt;
   logic [DATA_WD-1:0] r_data, d_mask, d_hi, d_lo, out_data_nxt;
   logic [DATA_BYTE_WD-1:0] out_keep_nxt;
   logic out_last_nxt, load_out, out_free, hdr_free, in_fire, strip_fire;
   function automatic logic [DATA_BYTE_WD-1:0] keep_left(input logic [CW-1:0] k);
      logic [DATA_BYTE_WD-1:0] ones;
      ones = '1;
      return ~(ones >> k);
   endfunction
   function automatic logic [DATA_BYTE_WD-1:0] keep_right(input logic [BYTE_CNT_WD-1:0] k);
      logic [DATA_BYTE_WD-1:0] ones;
      ones = '1;
      return ~(ones << k);
   endfunction
   // Bytes outside keep_in are zeroed so they never leak into payload or header.
   always_comb begin
      n = '0;
      d_mask = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++) begin
         n = n + CW'(keep_in[DATA_BYTE_WD-1-i]);
         d_mask[DATA_WD-1-8*i -: 8] = keep_in[DATA_BYTE_WD-1-i] ? data_in[DATA_WD-1-8*i -: 8] : 8'h00;
      end
   end
   assign cc   = {1'b0, c};
   assign d_hi = d_mask >> (8 * (DATA_BYTE_WD - int'(c)));
   assign d_lo = d_mask << (8 * int'(c));
   assign rem  = n > cc ? n - cc : '0;
   assign take = n < cc ? n : cc;
`ifdef AXIS_STRIP_HEADER_OUT_EN
   assign hdr_free = !valid_header || ready_header;
`else
   assign hdr_free = 1'b1;
`endif
   assign out_free    = !valid_out || ready_out;
   assign ready_strip = state == IDLE;
   assign ready_in    = (state == FIRST && hdr_free) || (state == BODY && out_free);
   assign in_fire     = valid_in && ready_in;
   assign strip_fire  = valid_strip && ready_strip;
   always_comb begin
      state_nxt    = state;
      load_out     = 1'b0;
      out_data_nxt = r_data | d_hi;
      out_keep_nxt = keep_left(r_cnt + take);
      out_last_nxt = last_in && n <= cc;
      case (state)
         IDLE:  state_nxt = strip_fire ? FIRST : IDLE;
         FIRST: state_nxt = !in_fire ? FIRST : !last_in ? BODY : rem != '0 ? FLUSH : IDLE;
         BODY: begin
            load_out  = in_fire;
            state_nxt = !(in_fire && last_in) ? BODY : n <= cc ? IDLE : FLUSH;
         end
         FLUSH: begin
            load_out     = out_free;
            state_nxt    = out_free ? IDLE : FLUSH;
            out_data_nxt = r_data;
            out_keep_nxt = keep_left(r_cnt);
            out_last_nxt = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         c         <= '0;
         r_data    <= '0;
         r_cnt     <= '0;
         valid_out <= 1'b0;
         data_out  <= '0;
         keep_out  <= '0;
         last_out  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (strip_fire) c <= byte_strip_cnt;
         if (in_fire) begin
            r_data <= d_lo;
            r_cnt  <= rem;
         end
         if (load_out) begin
            valid_out <= 1'b1;
            data_out  <= out_data_nxt;
            keep_out  <= out_keep_nxt;
            last_out  <= out_last_nxt;
         end else if (ready_out) begin
            valid_out <= 1'b0;
         end
      end
   end
`ifdef AXIS_STRIP_HEADER_OUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_header <= 1'b0;
         data_header  <= '0;
         keep_header  <= '0;
      end else if (in_fire && state == FIRST) begin
         valid_header <= 1'b1;
         data_header  <= d_hi;
         keep_header  <= keep_right(c);
      end else if (ready_header) begin
         valid_header <= 1'b0;
      end
   end
`else
   logic unused_ready_header;
   assign unused_ready_header = ready_header;
   assign valid_header = 1'b0;
   assign data_header  = '0;
   assign keep_header  = '0;
`endif
endmodule

// File: doc/axi_stream_strip_header.md
# axi_stream_strip_header

Removes a per-packet header of 0..DATA_BYTE_WD-1 bytes from the front of an AXI-Stream packet. It returns the stripped bytes on a separate header port and re-aligns the remaining payload MSB-first. It is the receive-side counterpart of the header-insertion block and sits between the link input stream and payload consumers. The byte order and keep conventions match that block: byte 0 is data[DATA_WD-1 -: 8], payload keep is left-aligned, and header keep is right-aligned.

## Interface
- DATA_WD, 32, stream data width in bits (multiple of 8)
- DATA_BYTE_WD, DATA_WD/8, bytes per beat
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of byte count

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_in / ready_in  in/out  1  input stream handshake
- data_in  in  DATA_WD  input beat
- keep_in  in  DATA_BYTE_WD  all ones except on last beat, where it is left-aligned (1..DATA_BYTE_WD ones)
- last_in  in  1  last beat of packet
- valid_out / ready_out  out/in  1  payload stream handshake
- data_out  out  DATA_WD  re-aligned payload; bytes not flagged by keep_out are 0
- keep_out  out  DATA_BYTE_WD  left-aligned byte enables
- last_out  out  1  last payload beat
- valid_strip / ready_strip  in/out  1  per-packet strip-length handshake
- byte_strip_cnt  in  BYTE_CNT_WD  header bytes c to strip (0..DATA_BYTE_WD-1)
- valid_header / ready_header  out/in  1  header output handshake
- data_header  out  DATA_WD  header bytes, right-aligned, upper bytes 0
- keep_header  out  DATA_BYTE_WD  ~({DATA_BYTE_WD{1'b1}} << c)

## Operation
- **States:**
  - IDLE: ready_strip=1. On a strip handshake, latch c and go to FIRST.
  - FIRST: waits for the first beat.
  - BODY: streams beats.
  - FLUSH: emits the residual beat.
- **Residual register R:** left-aligned, with byte count r.
- **FIRST beat acceptance:** the beat D with n = popcount(keep_in) valid bytes is accepted only when the header register is free (!valid_header | ready_header).
  - Load data_header = D >> 8*(DATA_BYTE_WD-c), keep_header as above, valid_header=1.
  - R = D << 8c, r = max(n-c, 0).
  - If last_in: with r>0, go to FLUSH; with r=0 (payload-empty), emit no payload beat and go to IDLE.
  - Otherwise go to BODY.
- **BODY beat D with n bytes** (accepted only when the output register is free):
  - data_out = R | (D >> 8*(DATA_BYTE_WD-c)).
  - Output byte count = r + min(n, c), with keep_out left-aligned to match.
  - R = D << 8c, r = max(n-c, 0).
  - If last_in and n<=c: last_out=1, go to IDLE.
  - If last_in and n>c: last_out=0, go to FLUSH.
- **FLUSH:** emit R with r bytes and last_out=1, then go to IDLE. ready_in=0 in this state.
- **c=0:** the block degenerates to a one-beat-delayed pass-through, and every packet ends through FLUSH.
- **Shifts:** a shift by DATA_WD yields 0; no wrap.

## Timing
- **Reset values:**
  - valid_out, data_out, keep_out, last_out = 0.
  - valid_header, data_header, keep_header = 0.
  - State is IDLE, so ready_strip=1 and ready_in=0.
- **Registered outputs:** data/header outputs are registered.
- **ready signals:** ready_in and ready_strip are combinational from state and output-register occupancy only. They never depend on valid_in in the same cycle.
- **Latency:** the first payload beat is visible 1 cycle after the second input beat is accepted, or 1 cycle after the first beat if that beat is last. The header is visible 1 cycle after the first beat is accepted.
- **Throughput:** 1 beat/cycle while ready_out=1, plus one FLUSH cycle when the last beat carries more than c bytes.
- **Backpressure:** valid_out/data_out/keep_out/last_out hold stable until accepted. A beat is accepted and a new one loaded in the same cycle when ready_out=1.
- **Strip handshake:** valid_strip while not in IDLE is ignored and stalled. Back-to-back packets have a 1-cycle IDLE gap.
- **Mid-packet reset:** reset asserted mid-packet aborts it. All outputs clear immediately and R is discarded.

## Configuration
- AXIS_STRIP_HEADER_OUT_EN defined: header port operates as above.
- Not defined:
  - Header bytes are discarded.
  - valid_header, data_header and keep_header are tied 0.
  - ready_header is ignored, and the FIRST beat does not wait on the header register.

## Test plan
- **Three-beat packet:** c=2; beats 0xAABBCCDD, 0x11223344, 0x55667788 (keep 1111, last).
  - Header 0x0000AABB/0011.
  - Output 0xCCDD1122/1111, 0x33445566/1111, then 0x77880000/1100 last.
- **Two-beat packet, short last:** c=3; 0x01020304, then 0x05060000 keep 1100 last.
  - Header 0x00010203/0111.
  - Single output 0x04050600/1110 last, no FLUSH.
- **Single-beat packet:** c=1; 0xDEADBEEF keep 1111 last.
  - Header 0x000000DE/0001.
  - Output 0xADBEEF00/1110 last.
- **Payload-empty packet:** c=3; 0x12345600 keep 1110 last.
  - Header 0x00123456/0111.
  - No payload beat; ready_strip=1 the next cycle.
- **Backpressure:**
  - ready_out=0 for 5 cycles mid-packet: outputs stay stable and ready_in=0; the byte stream is intact afterwards.
  - ready_header=0 at FIRST while a header is still pending: ready_in=0 until that header is accepted.
- **Reset mid-packet:** rst_n=0 in BODY.
  - All outputs become 0 immediately.
  - After release: ready_strip=1, and the next packet is processed correctly.
